// File: rtl/reorder_buffer_pkg.sv
// rtl/reorder_buffer_pkg.sv - shared ROB constants; define ROB_QUERY_BYPASS_EN to forward the CDB into operand lookups
package reorder_buffer_pkg;

   localparam int ROB_DEPTH = 32;
   localparam int ROB_TAG_W = 5;
   localparam int XLEN      = 32;
   localparam int RD_W      = 5;

   // Bit positions inside the per-entry flag word
   localparam int F_BUSY      = 0;
   localparam int F_READY     = 1;
   localparam int F_HAS_RD    = 2;
   localparam int F_IS_BRANCH = 3;
   localparam int F_IS_STORE  = 4;
   localparam int FLAG_W      = 5;

   typedef logic [FLAG_W-1:0] rob_flags_t;

   localparam logic ENABLE  = 1'b1;
   localparam logic DISABLE = 1'b0;

`ifdef ROB_QUERY_BYPASS_EN
   localparam logic ROB_QUERY_BYPASS = ENABLE;
`else
   localparam logic ROB_QUERY_BYPASS = DISABLE;
`endif

endpackage

// File: rtl/reorder_buffer_query.sv
// rtl/reorder_buffer_query.sv - operand tag lookup into the ROB, with CDB forwarding when ROB_QUERY_BYPASS_EN is defined
module rob_operand_query
   import reorder_buffer_pkg::*;
#(
   parameter int DEPTH = ROB_DEPTH,
   parameter int TAG_W = ROB_TAG_W
)(
   input  logic [TAG_W-1:0] i_tag,
   input  logic [DEPTH-1:0] i_busy,
   input  logic [DEPTH-1:0] i_ready,
   input  logic [XLEN-1:0]  i_value [DEPTH],
   input  logic             i_cdb_valid,
   input  logic [TAG_W-1:0] i_cdb_tag,
   input  logic [XLEN-1:0]  i_cdb_value,
   output logic             o_ready,
   output logic [XLEN-1:0]  o_value
);

   logic w_stored_ready;
   logic w_hit;

   // A hit on the live broadcast wins over the stored copy, which is one cycle stale
   assign w_stored_ready = i_busy[i_tag] && i_ready[i_tag];
   assign w_hit          = ROB_QUERY_BYPASS && i_cdb_valid && (i_cdb_tag == i_tag);
   assign o_ready        = w_hit || w_stored_ready;
   assign o_value        = w_hit ? i_cdb_value : i_value[i_tag];

endmodule

// File: rtl/reorder_buffer.sv
// rtl/reorder_buffer.sv - circular in-order retirement queue between dispatch/CDB and the register file
module reorder_buffer
   import reorder_buffer_pkg::*;
#(
   parameter int DEPTH = ROB_DEPTH,
   parameter int TAG_W = ROB_TAG_W
)(
   input  logic             clk,
   input  logic             rst,
   input  logic             i_rdy,
   input  logic             i_disp_valid,
   input  logic             i_disp_has_rd,
   input  logic [RD_W-1:0]  i_disp_rd,
   input  logic             i_disp_is_branch,
   input  logic             i_disp_is_store,
   input  logic             i_disp_pred_taken,
   input  logic [XLEN-1:0]  i_disp_pred_pc,
   output logic [TAG_W-1:0] o_disp_tag,
   output logic             o_full,
   input  logic             i_cdb_valid,
   input  logic [TAG_W-1:0] i_cdb_tag,
   input  logic [XLEN-1:0]  i_cdb_value,
   input  logic [XLEN-1:0]  i_cdb_next_pc,
   input  logic [TAG_W-1:0] i_q1_tag,
   input  logic [TAG_W-1:0] i_q2_tag,
   output logic             o_q1_ready,
   output logic             o_q2_ready,
   output logic [XLEN-1:0]  o_q1_value,
   output logic [XLEN-1:0]  o_q2_value,
   output logic             o_commit_valid,
   output logic [RD_W-1:0]  o_commit_rd,
   output logic [TAG_W-1:0] o_commit_tag,
   output logic [XLEN-1:0]  o_commit_value,
   output logic             o_store_commit,
   output logic             o_clr,
   output logic [XLEN-1:0]  o_clr_pc
);

   rob_flags_t       r_flags   [DEPTH];
   logic [RD_W-1:0]  r_rd      [DEPTH];
   logic [XLEN-1:0]  r_pred_pc [DEPTH];
   logic [XLEN-1:0]  r_value   [DEPTH];
   logic [XLEN-1:0]  r_next_pc [DEPTH];
   logic [TAG_W-1:0] r_head;
   logic [TAG_W-1:0] r_tail;
   logic [TAG_W:0]   r_count;

   logic             r_commit_valid;
   logic [RD_W-1:0]  r_commit_rd;
   logic [TAG_W-1:0] r_commit_tag;
   logic [XLEN-1:0]  r_commit_value;
   logic             r_store_commit;
   logic             r_clr;
   logic [XLEN-1:0]  r_clr_pc;

   logic             w_full;
   logic             w_alloc;
   logic             w_wb;
   logic             w_retire;
   logic             w_mispredict;
   rob_flags_t       w_head_flags;
   rob_flags_t       w_new_flags;
   logic [DEPTH-1:0] w_busy_vec;
   logic [DEPTH-1:0] w_ready_vec;
   logic             w_unused_pred_taken;

   // The predicted PC already encodes the taken decision, so only the PC is compared
   assign w_unused_pred_taken = i_disp_pred_taken;

   // Full is based on the registered count, so a retiring full buffer still rejects dispatch
   assign w_full       = (r_count == (TAG_W+1)'(DEPTH));
   assign w_alloc      = i_disp_valid && !w_full && !r_clr;
   assign w_wb         = i_cdb_valid && !r_clr;
   assign w_head_flags = r_flags[r_head];
   assign w_retire     = (r_count != '0) && w_head_flags[F_BUSY] && w_head_flags[F_READY];
   assign w_mispredict = w_retire && w_head_flags[F_IS_BRANCH] &&
                         (r_next_pc[r_head] != r_pred_pc[r_head]);

   // Flag word for a freshly dispatched entry: busy, not yet ready
   always_comb begin
      w_new_flags              = '0;
      w_new_flags[F_BUSY]      = 1'b1;
      w_new_flags[F_HAS_RD]    = i_disp_has_rd;
      w_new_flags[F_IS_BRANCH] = i_disp_is_branch;
      w_new_flags[F_IS_STORE]  = i_disp_is_store;
   end

   // Flatten busy/ready bits for the two operand lookups
   always_comb begin
      w_busy_vec  = '0;
      w_ready_vec = '0;
      for (int i = 0; i < DEPTH; i++) begin
         w_busy_vec[i]  = r_flags[i][F_BUSY];
         w_ready_vec[i] = r_flags[i][F_READY];
      end
   end

   // Entry, pointer and commit-port update; a mispredict flush overrides everything else
   always_ff @(posedge clk) begin
      if (rst) begin
         r_head         <= '0;
         r_tail         <= '0;
         r_count        <= '0;
         for (int i = 0; i < DEPTH; i++) r_flags[i] <= '0;
         r_commit_valid <= 1'b0;
         r_commit_rd    <= '0;
         r_commit_tag   <= '0;
         r_commit_value <= '0;
         r_store_commit <= 1'b0;
         r_clr          <= 1'b0;
         r_clr_pc       <= '0;
      end else if (!i_rdy) begin
         r_commit_valid <= 1'b0;
         r_store_commit <= 1'b0;
         r_clr          <= 1'b0;
      end else begin
         r_commit_valid <= 1'b0;
         r_store_commit <= 1'b0;
         r_clr          <= 1'b0;
         if (w_wb) begin
            r_flags[i_cdb_tag][F_READY] <= 1'b1;
            r_value[i_cdb_tag]          <= i_cdb_value;
            r_next_pc[i_cdb_tag]        <= i_cdb_next_pc;
         end
         if (w_alloc) begin
            r_flags[r_tail]   <= w_new_flags;
            r_rd[r_tail]      <= i_disp_rd;
            r_pred_pc[r_tail] <= i_disp_pred_pc;
            r_tail            <= r_tail + TAG_W'(1);
         end
         if (w_retire) begin
            r_commit_valid          <= w_head_flags[F_HAS_RD];
            r_commit_rd             <= w_head_flags[F_HAS_RD] ? r_rd[r_head] : '0;
            r_commit_tag            <= r_head;
            r_commit_value          <= r_value[r_head];
            r_store_commit          <= w_head_flags[F_IS_STORE];
            r_flags[r_head][F_BUSY] <= 1'b0;
            r_head                  <= r_head + TAG_W'(1);
         end
         r_count <= r_count + (TAG_W+1)'(w_alloc) - (TAG_W+1)'(w_retire);
         if (w_mispredict) begin
            r_clr    <= 1'b1;
            r_clr_pc <= r_next_pc[r_head];
            for (int i = 0; i < DEPTH; i++) r_flags[i] <= '0;
            r_head   <= '0;
            r_tail   <= '0;
            r_count  <= '0;
         end
      end
   end

   rob_operand_query #(.DEPTH(DEPTH), .TAG_W(TAG_W)) u_q1 (
      .i_tag       (i_q1_tag),
      .i_busy      (w_busy_vec),
      .i_ready     (w_ready_vec),
      .i_value     (r_value),
      .i_cdb_valid (i_cdb_valid),
      .i_cdb_tag   (i_cdb_tag),
      .i_cdb_value (i_cdb_value),
      .o_ready     (o_q1_ready),
      .o_value     (o_q1_value)
   );

   rob_operand_query #(.DEPTH(DEPTH), .TAG_W(TAG_W)) u_q2 (
      .i_tag       (i_q2_tag),
      .i_busy      (w_busy_vec),
      .i_ready     (w_ready_vec),
      .i_value     (r_value),
      .i_cdb_valid (i_cdb_valid),
      .i_cdb_tag   (i_cdb_tag),
      .i_cdb_value (i_cdb_value),
      .o_ready     (o_q2_ready),
      .o_value     (o_q2_value)
   );

   assign o_disp_tag     = r_tail;
   assign o_full         = w_full;
   assign o_commit_valid = r_commit_valid;
   assign o_commit_rd    = r_commit_rd;
   assign o_commit_tag   = r_commit_tag;
   assign o_commit_value = r_commit_value;
   assign o_store_commit = r_store_commit;
   assign o_clr          = r_clr;
   assign o_clr_pc       = r_clr_pc;

endmodule

// File: doc/reorder_buffer.md
Name: reorder_buffer

Overview:
- Circular in-order retirement queue between Dispatch/CDB and the register file.
- Dispatch allocates one entry per cycle at the tail; the returned tag is the entry index.
- The CDB marks entries ready. The head retires one entry per cycle and drives the regfile write port.
- A mispredicted branch at the head raises clr for one cycle, which flushes the whole out-of-order backend.

Parameters:
- DEPTH, 32, number of entries (power of two).
- TAG_W, 5, log2(DEPTH); matches ROBBus.
- XLEN, 32, data and PC width.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- rdy  in  1  global stall; low freezes state
- disp_valid  in  1  allocate an entry this cycle
- disp_has_rd  in  1  instruction writes rd
- disp_rd  in  5  destination register
- disp_is_branch  in  1  conditional branch or JALR
- disp_is_store  in  1  store instruction
- disp_pred_taken  in  1  predictor decision
- disp_pred_pc  in  XLEN  PC fetched after this instruction
- disp_tag  out  TAG_W  tail index; valid when !full
- full  out  1  count==DEPTH
- cdb_valid  in  1  result broadcast
- cdb_tag  in  TAG_W  producing entry
- cdb_value  in  XLEN  rd result
- cdb_next_pc  in  XLEN  resolved next PC (branches)
- q1_tag, q2_tag  in  TAG_W  operand lookup tags from Dispatch
- q1_ready, q2_ready  out  1  entry result available
- q1_value, q2_value  out  XLEN  entry result
- commit_valid  out  1  regfile write strobe (ROB_write_S)
- commit_rd  out  5  regfile rd; 0 when no rd
- commit_tag  out  TAG_W  retired index (ROB_Reorder)
- commit_value  out  XLEN  retired result
- store_commit  out  1  one-cycle pulse: head store may write memory
- clr  out  1  flush pulse
- clr_pc  out  XLEN  redirect PC

Behaviour:
- State:
  - Per-entry fields: busy, ready, has_rd, rd, is_branch, is_store, pred_pc, value, next_pc.
  - Pointers: head, tail (TAG_W bits, wrap modulo DEPTH); count (TAG_W+1 bits).
- Reset (rst=1 at posedge):
  - head=tail=count=0; all busy=0.
  - commit_valid=0, commit_rd=0, commit_tag=0, commit_value=0, store_commit=0, clr=0, clr_pc=0.
- rdy=0 edge: no state change; commit_valid, store_commit and clr are forced to 0.
- Allocate (disp_valid && !full && !clr):
  - Entry[tail] is written with busy=1, ready=0; tail++, count++.
  - disp_valid while full is ignored and counts as a protocol error.
- Writeback (cdb_valid && !clr):
  - Entry[cdb_tag] gets ready=1, value, next_pc.
  - Stores are dispatched with ready=0 and become ready via the CDB when address and data are known.
- Retire (count!=0 && entry[head].ready):
  - Registered outputs next edge: commit_valid=has_rd, commit_rd, commit_tag=head, commit_value.
  - store_commit=is_store. head++, count--, busy[head]=0.
- Mispredict: the retiring entry has is_branch && next_pc!=pred_pc.
  - Retire as above, and the same edge sets clr=1, clr_pc=next_pc.
  - Same edge flushes: all busy=0, head=tail=0, count=0. Any same-edge allocate or writeback is discarded.
  - While clr=1, allocate and writeback are ignored and no retire occurs (buffer empty).
  - clr drops after one cycle.
  - commit_valid with clr=1 is legal; the regfile writes V while clearing T.
- Simultaneous allocate and retire: count unchanged. Full plus retire does not admit dispatch the same cycle (full is registered-count based).
- Writeback to the head in the same cycle: retire occurs the following edge (ready is read from state).
- Pulse outputs are 0 on every edge without a retire.
- Query ports are combinational: qN_ready=busy[qN_tag]&&ready[qN_tag]; qN_value=value[qN_tag].
- Latency: CDB to commit_valid is at least 2 edges.

Optional Feature:
- Macro ROB_QUERY_BYPASS_EN.
- Defined: if cdb_valid && cdb_tag==qN_tag, then qN_ready=1 and qN_value=cdb_value in the same cycle.
- Undefined: lookups see only stored state; the result is visible one cycle after the CDB.

Decomposition:
- Shared package/header holds:
  - ROB_DEPTH, ROB_TAG_W, XLEN.
  - Entry-field bit positions.
  - Enable/Disable constants.
- One natural sub-module: rob_operand_query, the combinational tag lookup plus optional bypass, instanced twice for q1 and q2.

Test Plan:
- Reset, then dispatch 3 ALU ops rd=1,2,3 (tags 0,1,2); CDB tags 2,0,1 with values 0x30,0x10,0x20 -> commits in order tags 0,1,2, rd 1,2,3, values 0x10,0x20,0x30, one per cycle.
- Dispatch 32 entries with no CDB -> full=1 at count 32; a 33rd disp_valid is ignored. Retire one -> full=0, next disp_tag=0 (wrap).
- Branch tag 0 with pred_pc=0x104; CDB next_pc=0x200; younger tags 1-3 in flight -> clr=1 for one cycle, clr_pc=0x200; next disp_tag=0, count 0.
- JALR rd=1, pred_pc=0x8, CDB value=0x14, next_pc=0x40 -> same cycle: commit_valid=1, commit_rd=1, commit_value=0x14, clr=1.
- Store at head, CDB ready -> store_commit=1, commit_valid=0 for exactly one cycle.
- q1_tag=5 while cdb_tag=5, value 0xAB -> q1_ready=1, q1_value=0xAB with ROB_QUERY_BYPASS_EN; q1_ready=0 without it.
